// File: rtl/dist_pkg.sv
// Shared definitions for the ping-pong distance engine.
//   mode_e   : constellation select carried on M
//   state_e  : frame FSM states
//   PIPE_LAT : registered stages between beat accept and memory write
//   cand()   : candidate points per constellation
//   beats()  : beats per frame, at least one even when cand < NCH
package dist_pkg;

  typedef enum logic [1:0] {
    M_BPSK  = 2'b00,
    M_QPSK  = 2'b01,
    M_QAM16 = 2'b10,
    M_QAM64 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam int PIPE_LAT = 2;

  function automatic int unsigned cand(input mode_e m);
    case (m)
      M_BPSK:  return 2;
      M_QPSK:  return 4;
      M_QAM16: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int unsigned beats(input mode_e m, input int unsigned nch);
    int unsigned b;
    b = cand(m) / nch;
    return (b == 0) ? 1 : b;
  endfunction

endpackage

// File: rtl/norm_lane.sv
// One squared-norm lane: re^2 + im^2 with unsigned saturation.
//   clk, rst : clock, async active-low reset
//   i_re/i_im: signed complex component of the accepted beat
//   i_pad    : lane unused by the constellation, forces all-ones
//   o_dist   : result, valid two cycles after the inputs
module norm_lane #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] i_re,
  input  logic signed [WIDTH-1:0] i_im,
  input  logic                    i_pad,
  output logic [OUT_WIDTH-1:0]    o_dist
);

  logic signed [2*WIDTH-1:0] w_sq_re, w_sq_im;
  logic [2*WIDTH-1:0]        r_sq_re, r_sq_im;
  logic                      r_pad;
  logic [2*WIDTH:0]          w_sum;
  logic                      w_ovf;

  assign w_sq_re = i_re * i_re;
  assign w_sq_im = i_im * i_im;

  // Squares are non-negative, so the 2W+1-bit sum never wraps.
  assign w_sum = {1'b0, r_sq_re} + {1'b0, r_sq_im};
  assign w_ovf = |w_sum[2*WIDTH:OUT_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sq_re <= '0;
      r_sq_im <= '0;
      r_pad   <= 1'b0;
      o_dist  <= '0;
    end else begin
      r_sq_re <= w_sq_re;
      r_sq_im <= w_sq_im;
      r_pad   <= i_pad;
      o_dist  <= (r_pad || w_ovf) ? '1 : w_sum[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dist_calc_pingpong.sv
// Squared-distance engine with a two-bank ping-pong result memory.
//   clk, rst          : clock, async active-low reset
//   start, M          : begin a frame and latch the constellation
//   in_valid/in_ready : beat handshake; in_re/in_im carry NCH signed lanes
//   rd_addr, rd_dist  : registered read of the oldest full bank
//   rd_release        : consumer done with rd_bank
//   rd_valid, rd_bank : a full bank is presented, and which one
//   busy, done        : frame in flight / one-cycle commit pulse
module dist_calc_pingpong
  import dist_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int NCH        = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               M,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NCH*WIDTH-1:0]     in_re,
  input  logic [NCH*WIDTH-1:0]     in_im,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic                     rd_release,
  output logic [NCH*OUT_WIDTH-1:0] rd_dist,
  output logic                     rd_valid,
  output logic                     rd_bank,
  output logic                     busy,
  output logic                     done
);

  localparam int MW = $clog2(2*DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  state_e                           r_state, w_next;
  mode_e                            r_mode;
  logic [ADDR_WIDTH-1:0]            r_cnt, w_last_idx;
  logic [PIPE_LAT:1]                r_vld_pipe;
  logic [PIPE_LAT:1][ADDR_WIDTH-1:0] r_addr_pipe;
  logic [1:0]                       r_full, w_full_nx;
  logic                             r_wr_bank, r_rd_bank, r_done;
  logic [NCH*OUT_WIDTH-1:0]         r_rd_dist;
  logic                             w_accept, w_start_ok, w_commit, w_release;
  logic [NCH-1:0]                   w_pad;
  logic [NCH-1:0][OUT_WIDTH-1:0]    w_lane_dist;
  logic [MW-1:0]                    w_wr_idx, w_rd_idx;

  logic [NCH*OUT_WIDTH-1:0] r_mem [2*DEPTH];

  assign w_accept   = (r_state == S_RUN) && in_valid;
  assign w_start_ok = (r_state == S_IDLE) && start && !r_full[r_wr_bank];
  assign w_last_idx = ADDR_WIDTH'(beats(r_mode, NCH) - 1);
  // In DRAIN nothing new enters, so an empty younger stage means the
  // word in the last stage is the frame's final beat.
  assign w_commit   = (r_state == S_DRAIN) && r_vld_pipe[PIPE_LAT] &&
                      !(|r_vld_pipe[PIPE_LAT-1:1]);
  assign w_release  = rd_release && (|r_full);

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_next = S_RUN;
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (w_accept && (r_cnt == w_last_idx)) w_next = S_DRAIN;
      end
      S_DRAIN: if (w_commit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Commit and release always target different banks, so both apply.
  always_comb begin
    w_full_nx = r_full;
    if (w_commit)  w_full_nx[r_wr_bank] = 1'b1;
    if (w_release) w_full_nx[r_rd_bank] = 1'b0;
  end

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_lane
      assign w_pad[k] = (32'(k) >= cand(r_mode));
      norm_lane #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_re   (in_re[k*WIDTH +: WIDTH]),
        .i_im   (in_im[k*WIDTH +: WIDTH]),
        .i_pad  (w_pad[k]),
        .o_dist (w_lane_dist[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mode      <= M_BPSK;
      r_cnt       <= '0;
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_done      <= 1'b0;
      r_rd_dist   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_mode <= mode_e'(M);
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_vld_pipe     <= {r_vld_pipe[PIPE_LAT-1:1], w_accept};
      r_addr_pipe[1] <= r_cnt;
      for (int i = 2; i <= PIPE_LAT; i++) r_addr_pipe[i] <= r_addr_pipe[i-1];
      r_full <= w_full_nx;
      if (w_commit)  r_wr_bank <= ~r_wr_bank;
      // Banks fill and drain in strict alternation, so the next oldest
      // bank is always the other one.
      if (w_release) r_rd_bank <= ~r_rd_bank;
      r_done <= w_commit;
      if ((|r_full) && ({1'b0, rd_addr} < DEPTH_L)) r_rd_dist <= r_mem[w_rd_idx];
    end
  end

  assign w_wr_idx = MW'(r_wr_bank ? DEPTH : 0) + MW'(r_addr_pipe[PIPE_LAT]);
  assign w_rd_idx = MW'(r_rd_bank ? DEPTH : 0) + MW'(rd_addr);

  always_ff @(posedge clk) begin
    if (r_vld_pipe[PIPE_LAT]) r_mem[w_wr_idx] <= w_lane_dist;
  end

  assign rd_dist  = r_rd_dist;
  assign rd_valid = |r_full;
  assign rd_bank  = r_rd_bank;
  assign done     = r_done;

endmodule

// File: tb/tb_dist_calc_pingpong.sv
module tb_dist_calc_pingpong;
  localparam int W = 16, OW = 16, NCH = 4, AW = 7, DEPTH = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, rd_release = 1'b0;
  logic [1:0] M = 2'b00;
  logic in_ready, rd_valid, rd_bank, busy, done;
  logic [NCH*W-1:0] in_re = '0, in_im = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [NCH*OW-1:0] rd_dist;

  always #5 clk = ~clk;

  dist_calc_pingpong #(.WIDTH(W), .OUT_WIDTH(OW), .NCH(NCH), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .rd_addr(rd_addr), .rd_release(rd_release),
    .rd_dist(rd_dist), .rd_valid(rd_valid), .rd_bank(rd_bank), .busy(busy), .done(done)
  );

  typedef struct {
    string            name;
    logic [1:0]       m;
    logic [3:0][15:0] re, im, exp;
  } vec_t;

  vec_t tv[4];
  logic [3:0][15:0] fr_re[16], fr_im[16];
  logic [3:0][15:0] w;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setl(input int i, input int k, input int re, input int im, input int ex);
    tv[i].re[k]  = 16'(re);
    tv[i].im[k]  = 16'(im);
    tv[i].exp[k] = 16'(ex);
  endtask

  // Start, stream nb beats (optionally with idle gaps), then expect done 3 cycles later.
  task automatic frame(input logic [1:0] m, input int nb, input bit gaps, input string nm);
    int got;
    @(posedge clk); #1 start = 1'b1; M = m;
    @(posedge clk); #1 start = 1'b0; M = ~m;
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b1; in_re = fr_re[b]; in_im = fr_im[b];
      @(negedge clk); chk({nm, " in_ready"}, 32'(in_ready), 1);
      @(posedge clk); #1 in_valid = 1'b0;
      if (gaps && b < nb - 1) begin
        @(negedge clk); chk({nm, " ready in gap"}, 32'(in_ready), 1);
        @(posedge clk); #1;
      end
    end
    got = 0;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(negedge clk);
      if (done) got = c;
    end
    chk({nm, " done latency"}, 32'(got), 3);
    @(negedge clk); chk({nm, " done single"}, 32'(done), 0);
  endtask

  task automatic rd(input int a, output logic [3:0][15:0] d);
    @(posedge clk); #1 rd_addr = AW'(a);
    @(posedge clk); @(negedge clk); d = rd_dist;
  endtask

  task automatic release_bank();
    @(posedge clk); #1 rd_release = 1'b1;
    @(posedge clk); #1 rd_release = 1'b0;
  endtask

  task automatic chk_word(input string nm, input logic [3:0][15:0] exp);
    for (int k = 0; k < 4; k++) chk($sformatf("%s lane%0d", nm, k), 32'(w[k]), 32'(exp[k]));
  endtask

  initial begin
    logic [3:0][15:0] e;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst rd_valid", 32'(rd_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst rd_bank", 32'(rd_bank), 0);
    chk("rst rd_dist", 32'(rd_dist[31:0]), 0);
    @(posedge clk); #1 rst = 1'b1;

    tv[0].name = "qpsk";  tv[0].m = 2'b01;
    setl(0, 0, 3, -4, 25);  setl(0, 1, 0, 0, 0);  setl(0, 2, -1, 1, 2);  setl(0, 3, 5, 12, 169);
    tv[1].name = "bpsk";  tv[1].m = 2'b00;
    setl(1, 0, 1, 1, 2);  setl(1, 1, 2, 0, 4);  setl(1, 2, 7, 7, 'hFFFF);  setl(1, 3, 0, 0, 'hFFFF);
    tv[2].name = "sat";   tv[2].m = 2'b01;
    setl(2, 0, -32768, -32768, 'hFFFF);  setl(2, 1, 255, 0, 65025);
    setl(2, 2, 256, 0, 'hFFFF);          setl(2, 3, -181, 180, 65161);
    tv[3].name = "edge";  tv[3].m = 2'b01;
    setl(3, 0, 255, 1, 65026);  setl(3, 1, 32767, 32767, 'hFFFF);
    setl(3, 2, -128, -128, 32768);  setl(3, 3, 0, -1, 1);

    for (int i = 0; i < 4; i++) begin
      fr_re[0] = tv[i].re; fr_im[0] = tv[i].im;
      frame(tv[i].m, 1, 1'b0, tv[i].name);
      chk({tv[i].name, " rd_valid"}, 32'(rd_valid), 1);
      chk({tv[i].name, " rd_bank"}, 32'(rd_bank), 32'(i % 2));
      rd(0, w);
      chk_word(tv[i].name, tv[i].exp);
      release_bank();
    end

    // 16QAM: four beats with idle gaps between them
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++) begin
        fr_re[b][k] = 16'(4*b + k);
        fr_im[b][k] = 16'(-(k + 1));
      end
    frame(2'b10, 4, 1'b1, "qam16");
    chk("qam16 rd_bank", 32'(rd_bank), 0);
    for (int b = 0; b < 4; b++) begin
      rd(b, w);
      for (int k = 0; k < 4; k++) e[k] = 16'((4*b + k) * (4*b + k) + (k + 1) * (k + 1));
      chk_word($sformatf("qam16 addr%0d", b), e);
    end
    release_bank();

    // both banks full: third start ignored until a release
    fr_re[0] = tv[0].re; fr_im[0] = tv[0].im;
    frame(2'b01, 1, 1'b0, "fillA");
    fr_re[0] = tv[1].re; fr_im[0] = tv[1].im;
    frame(2'b00, 1, 1'b0, "fillB");
    chk("full rd_bank oldest", 32'(rd_bank), 1);
    @(posedge clk); #1 start = 1'b1; M = 2'b01;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("full start busy", 32'(busy), 0);
    chk("full start in_ready", 32'(in_ready), 0);
    release_bank();
    @(negedge clk);
    chk("after release rd_bank", 32'(rd_bank), 0);
    chk("after release rd_valid", 32'(rd_valid), 1);
    rd(0, w);
    chk_word("bankB", tv[1].exp);
    fr_re[0] = tv[2].re; fr_im[0] = tv[2].im;
    frame(2'b01, 1, 1'b0, "reuse");
    release_bank();
    @(negedge clk);
    chk("reuse rd_bank", 32'(rd_bank), 1);
    rd(0, w);
    chk_word("reuse", tv[2].exp);

    // reset in the middle of a 16QAM frame, with bank 1 still full
    @(posedge clk); #1 start = 1'b1; M = 2'b10;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_re = fr_re[0]; in_im = fr_im[0];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid rst in_ready", 32'(in_ready), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst rd_valid", 32'(rd_valid), 0);
    chk("mid rst rd_bank", 32'(rd_bank), 0);
    chk("mid rst done", 32'(done), 0);
    chk("mid rst rd_dist", 32'(rd_dist[31:0]), 0);
    @(posedge clk); #1 rst = 1'b1;
    fr_re[0] = tv[0].re; fr_im[0] = tv[0].im;
    frame(2'b01, 1, 1'b0, "post rst");
    chk("post rst rd_bank", 32'(rd_bank), 0);
    rd(0, w);
    chk_word("post rst", tv[0].exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
